systolic_controller: RTL

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

---
 rtl/systolic_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/systolic_controller.sv
// Systolic array tile sequencer: weight load, ifmap streaming, pipeline drain.
// Tracks in-flight vectors with a stall-aware valid delay line.
module systolic_controller #(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int MAX_VECS     = 256,
  localparam int AW       = $clog2(MAX_VECS),
  localparam int PIPE_LAT = ARRAY_HEIGHT + ARRAY_WIDTH - 1,
  localparam int RW       = $clog2(ARRAY_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   num_vecs,
  input  logic          stall,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          weight_en,
  output logic [RW-1:0] weight_row,
  output logic          ifmap_rd_en,
  output logic [AW-1:0] ifmap_addr,
  output logic          array_en,
  output logic          ofmap_valid,
  output logic [AW-1:0] ofmap_addr
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, COMPUTE, DRAIN, DONE
  } state_t;

  state_t state;

  logic [AW-1:0]       nv_last;
  logic [AW-1:0]       rd_cnt;
  logic [AW-1:0]       wr_cnt;
  logic [RW-1:0]       w_cnt;
  logic [DW-1:0]       d_cnt;
  logic [PIPE_LAT-1:0] vld_dl;

  logic run;
  logic rd_fire;
  logic wr_fire;

  assign run     = (state == COMPUTE || state == DRAIN) && !stall;
  assign rd_fire = (state == COMPUTE) && !stall;
  assign wr_fire = run && vld_dl[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nv_last <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      w_cnt   <= '0;
      d_cnt   <= '0;
      vld_dl  <= '0;
    end else if (abort) begin
      state   <= IDLE;
      nv_last <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      w_cnt   <= '0;
      d_cnt   <= '0;
      vld_dl  <= '0;
    end else begin
      if (run)
        vld_dl <= {vld_dl[PIPE_LAT-2:0], rd_fire};
      if (wr_fire)
        wr_cnt <= wr_cnt + AW'(1);
      unique case (state)
        IDLE: begin
          if (start && num_vecs == '0) begin
            state <= DONE;
          end else if (start && num_vecs <= (AW+1)'(MAX_VECS)) begin
            state   <= LOAD_W;
            nv_last <= AW'(num_vecs - (AW+1)'(1));
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            w_cnt   <= '0;
            d_cnt   <= '0;
            vld_dl  <= '0;
          end
        end
        LOAD_W: begin
          if (w_cnt == RW'(ARRAY_HEIGHT - 1)) begin
            state <= COMPUTE;
            w_cnt <= '0;
          end else begin
            w_cnt <= w_cnt + RW'(1);
          end
        end
        COMPUTE: begin
          if (!stall) begin
            if (rd_cnt == nv_last)
              state <= DRAIN;
            else
              rd_cnt <= rd_cnt + AW'(1);
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (d_cnt == DW'(PIPE_LAT - 1)) begin
              state <= DONE;
              d_cnt <= '0;
            end else begin
              d_cnt <= d_cnt + DW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          rd_cnt <= '0;
          wr_cnt <= '0;
          vld_dl <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = state != IDLE;
  assign done        = (state == DONE) && !abort;
  assign weight_en   = state == LOAD_W;
  assign weight_row  = w_cnt;
  assign ifmap_rd_en = rd_fire;
  assign ifmap_addr  = (state == COMPUTE) ? rd_cnt : '0;
  assign array_en    = run;
  assign ofmap_valid = wr_fire;
  assign ofmap_addr  = wr_cnt;

endmodule
